jt12_bus_arb: RTL and testbench

//  Shares the single jt12 CPU write port between two requesters (cpu0 = 68k side, cpu1 = Z80 side).

---
 rtl/jt12_arb_pkg.sv | 20 ++
 rtl/jt12_bus_arb_if.sv | 32 +++
 rtl/jt12_arb_rr.sv | 22 ++
 rtl/jt12_bus_arb.sv | 169 ++++++++++++++++
 tb/tb_jt12_bus_arb.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jt12_arb_pkg.sv
// Shared types and constants for the jt12 two-requester write-port arbiter.
package jt12_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStrobe = 2'd1,
    StRise   = 2'd2,
    StFall   = 2'd3
  } arb_state_e;

  localparam int unsigned BUSY_BIT = 7;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/jt12_bus_arb_if.sv
// Bus bundle between the two CPU-side requesters, the arbiter and the jt12 write port.
interface jt12_bus_arb_if;

  logic       cpu0_req;
  logic [1:0] cpu0_addr;
  logic [7:0] cpu0_din;
  logic       cpu0_ack;
  logic       cpu1_req;
  logic [1:0] cpu1_addr;
  logic [7:0] cpu1_din;
  logic       cpu1_ack;
  logic       fm_cs_n;
  logic       fm_wr_n;
  logic [1:0] fm_addr;
  logic [7:0] fm_din;
  logic [7:0] fm_dout;
  logic       owner;
  logic       to_err;

  // Arbiter side.
  modport master (
    input  cpu0_req, cpu0_addr, cpu0_din, cpu1_req, cpu1_addr, cpu1_din, fm_dout,
    output cpu0_ack, cpu1_ack, fm_cs_n, fm_wr_n, fm_addr, fm_din, owner, to_err
  );

  // Requester / chip side.
  modport slave (
    output cpu0_req, cpu0_addr, cpu0_din, cpu1_req, cpu1_addr, cpu1_din, fm_dout,
    input  cpu0_ack, cpu1_ack, fm_cs_n, fm_wr_n, fm_addr, fm_din, owner, to_err
  );

endinterface

// File: rtl/jt12_arb_rr.sv
// Two-way round-robin picker; while the pair lock is held only the owner is eligible.
module jt12_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock,
  input  logic       owner,
  output logic       gnt_vld,
  output logic       gnt
);

  logic [1:0] elig;

  always_comb begin
    elig = req;
    if (lock) begin
      elig = owner ? (req & 2'b10) : (req & 2'b01);
    end
    gnt_vld = |elig;
    gnt     = (&elig) ? ~last : elig[1];
  end

endmodule

// File: rtl/jt12_bus_arb.sv
// Shares the jt12 write port between two requesters: round-robin, atomic address/data
// pairs, writes paced on the registered busy flag.
module jt12_bus_arb
  import jt12_arb_pkg::*;
#(
  parameter int unsigned WR_CYCLES = 2,
  parameter int unsigned RISE_MAX  = 4,
  parameter int unsigned BUSY_TO   = 255,
  parameter int unsigned LOCK_TO   = 63
) (
  input  logic           clk,
  input  logic           rst_n,
  jt12_bus_arb_if.master bus
);

  localparam int unsigned CntW  = $clog2(max3(WR_CYCLES, RISE_MAX, BUSY_TO) + 1);
  localparam int unsigned LockW = $clog2(LOCK_TO + 1);
  localparam logic [CntW-1:0]  WrLast   = CntW'(WR_CYCLES - 1);
  localparam logic [CntW-1:0]  AckAt    = CntW'(WR_CYCLES - 2);
  localparam logic [CntW-1:0]  RiseLast = CntW'(RISE_MAX - 1);
  localparam logic [CntW-1:0]  BusyLast = CntW'(BUSY_TO - 1);
  localparam logic [LockW-1:0] LockLast = LockW'(LOCK_TO - 1);

  arb_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
  logic             lock_q, lock_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             strobe_n_q, strobe_n_d;
  logic [1:0]       fm_addr_q, fm_addr_d;
  logic [7:0]       fm_din_q, fm_din_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             to_err_q, to_err_d;
  logic             busy_q;
  logic             gnt_vld, gnt;
  logic             owner_req;

  jt12_arb_rr u_rr (
    .req     ({bus.cpu1_req, bus.cpu0_req}),
    .last    (last_q),
    .lock    (lock_q),
    .owner   (owner_q),
    .gnt_vld (gnt_vld),
    .gnt     (gnt)
  );

  assign owner_req = owner_q ? bus.cpu1_req : bus.cpu0_req;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lock_cnt_d = lock_cnt_q;
    lock_d     = lock_q;
    owner_d    = owner_q;
    last_d     = last_q;
    strobe_n_d = strobe_n_q;
    fm_addr_d  = fm_addr_q;
    fm_din_d   = fm_din_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    to_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt_vld) begin
          fm_addr_d  = gnt ? bus.cpu1_addr : bus.cpu0_addr;
          fm_din_d   = gnt ? bus.cpu1_din : bus.cpu0_din;
          owner_d    = gnt;
          last_d     = gnt;
          cnt_d      = '0;
          lock_cnt_d = '0;
          strobe_n_d = 1'b0;
          state_d    = StStrobe;
          // Single-cycle strobe: the ack must already be armed at grant.
          if (WR_CYCLES == 1) begin
            ack0_d = ~gnt;
            ack1_d = gnt;
          end
        end else if (lock_q && !owner_req) begin
          if (lock_cnt_q == LockLast) begin
            lock_d     = 1'b0;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
      end
      StStrobe: begin
        if (cnt_q == WrLast) begin
          strobe_n_d = 1'b1;
          lock_d     = ~fm_addr_q[0];
          cnt_d      = '0;
          state_d    = StRise;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (WR_CYCLES > 1 && cnt_q == AckAt) begin
            ack0_d = ~owner_q;
            ack1_d = owner_q;
          end
        end
      end
      StRise: begin
        if (busy_q) begin
          cnt_d   = '0;
          state_d = StFall;
        end else if (cnt_q == RiseLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFall: begin
        if (!busy_q) begin
          state_d = StIdle;
        end else if (cnt_q == BusyLast) begin
          to_err_d = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      strobe_n_q <= 1'b1;
      fm_addr_q  <= '0;
      fm_din_q   <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      to_err_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lock_cnt_q <= lock_cnt_d;
      lock_q     <= lock_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      strobe_n_q <= strobe_n_d;
      fm_addr_q  <= fm_addr_d;
      fm_din_q   <= fm_din_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      to_err_q   <= to_err_d;
      busy_q     <= bus.fm_dout[BUSY_BIT];
    end
  end

  // cs_n and wr_n share one flop so they can never diverge.
  assign bus.fm_cs_n  = strobe_n_q;
  assign bus.fm_wr_n  = strobe_n_q;
  assign bus.fm_addr  = fm_addr_q;
  assign bus.fm_din   = fm_din_q;
  assign bus.cpu0_ack = ack0_q;
  assign bus.cpu1_ack = ack1_q;
  assign bus.owner    = owner_q;
  assign bus.to_err   = to_err_q;

endmodule

// File: tb/tb_jt12_bus_arb.sv
// Scoreboarded bench for jt12_bus_arb: a busy-flag chip model, a strobe monitor and
// one task per scenario.
module tb_jt12_bus_arb;

  localparam int unsigned WR = 2;

  typedef struct packed {
    logic       who;
    logic [1:0] addr;
    logic [7:0] din;
    logic [3:0] slen;
    logic       ack_who;
    logic [3:0] ack_pos;
    logic       wr_bad;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  jt12_bus_arb_if bus ();

  jt12_bus_arb #(
    .WR_CYCLES (WR),
    .RISE_MAX  (4),
    .BUSY_TO   (255),
    .LOCK_TO   (63)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;

  // Chip model: busy rises while the strobe is seen low, then holds busy_len cycles.
  int   busy_len = 5;
  logic stuck = 1'b0;
  int   busy_cnt = 0;
  logic busy;
  assign busy        = stuck || (busy_cnt != 0);
  assign bus.fm_dout = {busy, 7'h00};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) busy_cnt <= 0;
    else if (!bus.fm_cs_n) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  // Monitor: records each completed strobe plus busy-fall, ack and to_err events.
  logic in_strobe = 1'b0;
  logic prev_busy = 1'b0;
  wr_t  cur = '0;
  int   last_start = 0, last_fall = 0, err_cyc = 0;
  int   ack0_cnt = 0, err_cnt = 0, stray_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      in_strobe = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (bus.cpu0_ack) ack0_cnt++;
      if (bus.to_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (prev_busy && !bus.fm_dout[7]) last_fall = cyc;
      prev_busy = bus.fm_dout[7];
      if (!bus.fm_cs_n || !bus.fm_wr_n) begin
        if (!in_strobe) begin
          in_strobe  = 1'b1;
          cur        = '0;
          cur.who    = bus.owner;
          cur.addr   = bus.fm_addr;
          cur.din    = bus.fm_din;
          last_start = cyc;
        end
        cur.slen = cur.slen + 4'd1;
        if (bus.fm_cs_n != bus.fm_wr_n) cur.wr_bad = 1'b1;
        if (bus.cpu0_ack || bus.cpu1_ack) begin
          cur.ack_who = bus.cpu1_ack;
          cur.ack_pos = cur.slen;
        end
      end else begin
        if (in_strobe) begin
          obs_q.push_back(cur);
          in_strobe = 1'b0;
        end
        if (bus.cpu0_ack || bus.cpu1_ack) stray_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  function automatic wr_t mk(input logic who, input logic [1:0] a, input logic [7:0] d);
    wr_t w;
    w.who     = who;
    w.addr    = a;
    w.din     = d;
    w.slen    = 4'(WR);
    w.ack_who = who;
    w.ack_pos = 4'(WR);
    w.wr_bad  = 1'b0;
    return w;
  endfunction

  task automatic do_reset();
    bus.cpu0_req = 1'b0;
    bus.cpu1_req = 1'b0;
    stuck = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
  endtask

  // Raises a request, waits (bounded) for its ack, then drops it.
  task automatic do_write(input logic who, input logic [1:0] a, input logic [7:0] d);
    bit got;
    got = 1'b0;
    if (who) begin
      bus.cpu1_addr = a; bus.cpu1_din = d; bus.cpu1_req = 1'b1;
    end else begin
      bus.cpu0_addr = a; bus.cpu0_din = d; bus.cpu0_req = 1'b1;
    end
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (who ? bus.cpu1_ack : bus.cpu0_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (who) bus.cpu1_req = 1'b0;
    else bus.cpu0_req = 1'b0;
    n_cmp++;
    if (got !== 1'b1) begin
      n_err++;
      $display("FAIL ack_timeout cpu%0d: got no ack in 1000 cycles, required an ack", who);
    end
  endtask

  task automatic test_reset();
    bus.cpu0_req = 1'b0; bus.cpu1_req = 1'b0;
    bus.cpu0_addr = '0; bus.cpu1_addr = '0; bus.cpu0_din = '0; bus.cpu1_din = '0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 8;
    if (bus.fm_cs_n !== 1'b1) begin n_err++; $display("FAIL rst_cs_n: got %b required 1", bus.fm_cs_n); end
    if (bus.fm_wr_n !== 1'b1) begin n_err++; $display("FAIL rst_wr_n: got %b required 1", bus.fm_wr_n); end
    if (bus.fm_addr !== 2'd0) begin n_err++; $display("FAIL rst_addr: got %h required 0", bus.fm_addr); end
    if (bus.fm_din !== 8'd0) begin n_err++; $display("FAIL rst_din: got %h required 0", bus.fm_din); end
    if (bus.cpu0_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack0: got %b required 0", bus.cpu0_ack); end
    if (bus.cpu1_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack1: got %b required 0", bus.cpu1_ack); end
    if (bus.owner !== 1'b0) begin n_err++; $display("FAIL rst_owner: got %b required 0", bus.owner); end
    if (bus.to_err !== 1'b0) begin n_err++; $display("FAIL rst_to_err: got %b required 0", bus.to_err); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    wr_t e, o;
    do_reset();
    busy_len = 5;
    exp_q.push_back(mk(1'b0, 2'd0, 8'h28));
    exp_q.push_back(mk(1'b0, 2'd1, 8'h3C));
    do_write(1'b0, 2'd0, 8'h28);
    do_write(1'b0, 2'd1, 8'h3C);
    // busy falls at F, busy_q at F+1, grant at F+2, strobe from F+3.
    n_cmp++;
    if (last_start !== last_fall + 3) begin
      n_err++;
      $display("FAIL t1_regrant: strobe at %0d, required %0d", last_start, last_fall + 3);
    end
    repeat (4) @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = '1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL t1_write: got %h required %h", o, e); end
    end
    n_cmp++;
    if (obs_q.size() !== 0) begin n_err++; $display("FAIL t1_extra: got %0d extra writes, required 0", obs_q.size()); end
  endtask

  task automatic test_round_robin();
    wr_t e, o;
    do_reset();
    busy_len = 3;
    exp_q.push_back(mk(1'b0, 2'd1, 8'hA0));
    exp_q.push_back(mk(1'b1, 2'd1, 8'hB0));
    exp_q.push_back(mk(1'b0, 2'd1, 8'hA1));
    exp_q.push_back(mk(1'b1, 2'd1, 8'hB1));
    fork
      begin do_write(1'b0, 2'd1, 8'hA0); do_write(1'b0, 2'd1, 8'hA1); end
      begin do_write(1'b1, 2'd1, 8'hB0); do_write(1'b1, 2'd1, 8'hB1); end
    join
    repeat (4) @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = '1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL t2_rr: got %h required %h", o, e); end
    end
    n_cmp++;
    if (obs_q.size() !== 0) begin n_err++; $display("FAIL t2_extra: got %0d extra writes, required 0", obs_q.size()); end
  endtask

  task automatic test_pair_lock();
    wr_t e, o;
    do_reset();
    busy_len = 5;
    exp_q.push_back(mk(1'b0, 2'd0, 8'h2B));
    exp_q.push_back(mk(1'b0, 2'd1, 8'hF0));
    exp_q.push_back(mk(1'b1, 2'd1, 8'h77));
    do_write(1'b0, 2'd0, 8'h2B);
    fork
      begin repeat (10) @(posedge clk); #1; do_write(1'b0, 2'd1, 8'hF0); end
      do_write(1'b1, 2'd1, 8'h77);
    join
    repeat (4) @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = '1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL t3_lock: got %h required %h", o, e); end
    end
    n_cmp++;
    if (obs_q.size() !== 0) begin n_err++; $display("FAIL t3_extra: got %0d extra writes, required 0", obs_q.size()); end
  endtask

  task automatic test_lock_timeout();
    wr_t e, o;
    do_reset();
    busy_len = 5;
    exp_q.push_back(mk(1'b0, 2'd2, 8'h30));
    exp_q.push_back(mk(1'b1, 2'd1, 8'h99));
    do_write(1'b0, 2'd2, 8'h30);
    do_write(1'b1, 2'd1, 8'h99);
    // IDLE from F+2; 63 locked idle cycles, grant at F+65, strobe at F+66.
    n_cmp++;
    if (last_start !== last_fall + 66) begin
      n_err++;
      $display("FAIL t4_lock_to: strobe at %0d, required %0d", last_start, last_fall + 66);
    end
    repeat (4) @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = '1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL t4_write: got %h required %h", o, e); end
    end
    n_cmp++;
    if (obs_q.size() !== 0) begin n_err++; $display("FAIL t4_extra: got %0d extra writes, required 0", obs_q.size()); end
  endtask

  task automatic test_busy_timeout();
    wr_t e, o;
    int  s0, err_base;
    do_reset();
    busy_len = 5;
    err_base = err_cnt;
    stuck = 1'b1;
    exp_q.push_back(mk(1'b0, 2'd1, 8'h11));
    exp_q.push_back(mk(1'b1, 2'd1, 8'h22));
    do_write(1'b0, 2'd1, 8'h11);
    s0 = last_start;
    do_write(1'b1, 2'd1, 8'h22);
    stuck = 1'b0;
    repeat (10) @(posedge clk); #1;
    // Strobe s0..s0+1, RISE s0+2, FALL s0+3..s0+257, to_err at s0+258.
    n_cmp += 2;
    if (err_cyc !== s0 + 258) begin
      n_err++;
      $display("FAIL t5_err_time: to_err at %0d, required %0d", err_cyc, s0 + 258);
    end
    if (err_cnt - err_base !== 1) begin
      n_err++;
      $display("FAIL t5_err_count: got %0d pulses, required 1", err_cnt - err_base);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = '1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL t5_write: got %h required %h", o, e); end
    end
    n_cmp++;
    if (obs_q.size() !== 0) begin n_err++; $display("FAIL t5_extra: got %0d extra writes, required 0", obs_q.size()); end
  endtask

  task automatic test_reset_mid_strobe();
    wr_t e, o;
    int  ack_base;
    bit  seen, got;
    do_reset();
    busy_len = 3;
    ack_base = ack0_cnt;
    seen = 1'b0;
    got = 1'b0;
    exp_q.push_back(mk(1'b0, 2'd1, 8'h55));
    @(posedge clk); #1;
    bus.cpu0_addr = 2'd1; bus.cpu0_din = 8'h55; bus.cpu0_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!bus.fm_cs_n) begin seen = 1'b1; break; end
    end
    n_cmp++;
    if (seen !== 1'b1) begin n_err++; $display("FAIL t6_strobe: got no strobe in 20 cycles, required one"); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (bus.fm_cs_n !== 1'b1) begin n_err++; $display("FAIL t6_cs_n: got %b required 1", bus.fm_cs_n); end
    if (bus.fm_wr_n !== 1'b1) begin n_err++; $display("FAIL t6_wr_n: got %b required 1", bus.fm_wr_n); end
    if (bus.cpu0_ack !== 1'b0) begin n_err++; $display("FAIL t6_ack: got %b required 0", bus.cpu0_ack); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (bus.cpu0_ack) begin got = 1'b1; break; end
    end
    bus.cpu0_req = 1'b0;
    repeat (4) @(posedge clk); #1;
    n_cmp += 2;
    if (got !== 1'b1) begin n_err++; $display("FAIL t6_reserve: got no ack after reset, required one"); end
    if (ack0_cnt - ack_base !== 1) begin
      n_err++;
      $display("FAIL t6_ack_count: got %0d acks, required 1", ack0_cnt - ack_base);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = '1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL t6_write: got %h required %h", o, e); end
    end
    n_cmp += 2;
    if (obs_q.size() !== 0) begin n_err++; $display("FAIL t6_extra: got %0d extra writes, required 0", obs_q.size()); end
    if (stray_cnt !== 0) begin n_err++; $display("FAIL stray_ack: got %0d acks outside a strobe, required 0", stray_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_pair_lock();
    test_lock_timeout();
    test_busy_timeout();
    test_reset_mid_strobe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
